// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
//   op, funct, zero, memready : datapath -> controller (IR fields, ALU flag, memory handshake)
//   pcen ... state            : controller -> datapath (mux selects, write enables, debug state)
// The controller connects through the master modport and the datapath through the slave modport.
interface multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;

  logic       pcen;
  logic       iord;
  logic       irwrite;
  logic       memwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       signext;
  logic       shiftl16;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct, zero, memready,
    output pcen, iord, irwrite, memwrite, memtoreg, regdst, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, signext, shiftl16, illegal, state
  );

  modport slave (
    output op, funct, zero, memready,
    input  pcen, iord, irwrite, memwrite, memtoreg, regdst, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, signext, shiftl16, illegal, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle MIPS core. One memory port is shared between
// instruction fetch and data access; one ALU computes PC+4, the branch target and
// the execute result.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; returns the FSM to FETCH and blocks all write enables
//   bus   : multicycle_controller_if.master (op/funct/zero/memready in, all controls out)
// Parameter ILLEGAL_HALT: 1 = unknown op/funct parks the FSM in HALT until reset,
//                         0 = unknown op/funct behaves as a NOP (DECODE -> FETCH).
module multicycle_controller #(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEXEC = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    IEXEC  = 4'd9,
    IWB    = 4'd10,
    JUMP   = 4'd11,
    HALT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam state_t ILLEGAL_NEXT = ILLEGAL_HALT ? HALT : FETCH;

  state_t state_q;
  state_t state_d;

  logic pcwrite;
  logic branch;
  logic irwrite_raw;
  logic memwrite_raw;
  logic regwrite_raw;

  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100001, 6'b100010, 6'b100011,
      6'b100100, 6'b100101, 6'b101010: funct_legal = 1'b1;
      default:                         funct_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010, 6'b100011: funct_alu = ALU_SUB;
      6'b100100:            funct_alu = ALU_AND;
      6'b100101:            funct_alu = ALU_OR;
      6'b101010:            funct_alu = ALU_SLT;
      default:              funct_alu = ALU_ADD;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = bus.memready ? DECODE : FETCH;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW:                       state_d = MEMADR;
          OP_RTYPE:                           state_d = funct_legal(bus.funct) ? RTEXEC : ILLEGAL_NEXT;
          OP_BEQ:                             state_d = BRANCH;
          OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI:  state_d = IEXEC;
          OP_J:                               state_d = JUMP;
          default:                            state_d = ILLEGAL_NEXT;
        endcase
      end
      MEMADR: state_d = (bus.op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  state_d = bus.memready ? MEMWB : MEMRD;
      MEMWB:  state_d = FETCH;
      MEMWR:  state_d = bus.memready ? FETCH : MEMWR;
      RTEXEC: state_d = ALUWB;
      ALUWB:  state_d = FETCH;
      BRANCH: state_d = FETCH;
      IEXEC:  state_d = IWB;
      IWB:    state_d = FETCH;
      JUMP:   state_d = FETCH;
      HALT:   state_d = HALT;
      default: state_d = FETCH;  // encodings 12-14 recover to FETCH
    endcase
  end

  // Output decode
  always_comb begin
    pcwrite        = 1'b0;
    branch         = 1'b0;
    irwrite_raw    = 1'b0;
    memwrite_raw   = 1'b0;
    regwrite_raw   = 1'b0;
    bus.iord       = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.regdst     = 1'b0;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = 2'b00;
    bus.pcsrc      = 2'b00;
    bus.alucontrol = 3'b000;
    bus.signext    = 1'b0;
    bus.shiftl16   = 1'b0;
    bus.illegal    = 1'b0;
    case (state_q)
      FETCH: begin
        bus.alusrcb    = 2'b01;
        bus.alucontrol = ALU_ADD;
        irwrite_raw    = bus.memready;
        pcwrite        = bus.memready;
      end
      DECODE: begin
        // Branch target is computed speculatively and parked in ALUOut.
        bus.alusrcb    = 2'b11;
        bus.alucontrol = ALU_ADD;
        bus.signext    = 1'b1;
      end
      MEMADR: begin
        bus.alusrca    = 1'b1;
        bus.alusrcb    = 2'b10;
        bus.alucontrol = ALU_ADD;
        bus.signext    = 1'b1;
      end
      MEMRD: bus.iord = 1'b1;
      MEMWB: begin
        bus.memtoreg = 1'b1;
        regwrite_raw = 1'b1;
      end
      MEMWR: begin
        // Strobe stays up for the whole handshake, not just the completing cycle.
        bus.iord     = 1'b1;
        memwrite_raw = 1'b1;
      end
      RTEXEC: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = funct_alu(bus.funct);
      end
      ALUWB: begin
        bus.regdst   = 1'b1;
        regwrite_raw = 1'b1;
      end
      BRANCH: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = ALU_SUB;
        bus.pcsrc      = 2'b01;
        branch         = 1'b1;
      end
      IEXEC: begin
        bus.alusrca    = 1'b1;
        bus.alusrcb    = 2'b10;
        bus.alucontrol = (bus.op == OP_ORI) ? ALU_OR : ALU_ADD;
        bus.signext    = (bus.op == OP_ADDI) || (bus.op == OP_ADDIU);
        bus.shiftl16   = (bus.op == OP_LUI);
      end
      IWB: regwrite_raw = 1'b1;
      JUMP: begin
        bus.pcsrc = 2'b10;
        pcwrite   = 1'b1;
      end
      HALT: bus.illegal = 1'b1;
      default: ;
    endcase
  end

  // Write enables are suppressed during reset so an interrupted instruction has no side effect.
  assign bus.pcen     = !reset && (pcwrite || (branch && bus.zero));
  assign bus.irwrite  = !reset && irwrite_raw;
  assign bus.memwrite = !reset && memwrite_raw;
  assign bus.regwrite = !reset && regwrite_raw;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_controller_if ifh ();
  multicycle_controller_if ifn ();

  assign ifn.op       = ifh.op;
  assign ifn.funct    = ifh.funct;
  assign ifn.zero     = ifh.zero;
  assign ifn.memready = ifh.memready;

  multicycle_controller #(.ILLEGAL_HALT(1'b1)) dut (.clk(clk), .reset(reset), .bus(ifh.master));
  multicycle_controller #(.ILLEGAL_HALT(1'b0)) dut_nop (.clk(clk), .reset(reset), .bus(ifn.master));

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, ADDIU = 6'b001001, ORI = 6'b001101, LUI = 6'b001111, J = 6'b000010;

  typedef struct {
    logic [3:0] st;
    logic       pcen, iord, irw, memw, m2r, rdst, regw, asrca;
    logic [1:0] asrcb, pcsrc;
    logic [2:0] alu;
    logic       sext, sh16, ill, rdy;
  } cyc_t;

  cyc_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected ALU operation for an R-type funct, straight from the ISA table.
  function automatic logic [2:0] r_alu(input logic [5:0] f);
    case (f)
      6'h20, 6'h21: r_alu = 3'b010;
      6'h22, 6'h23: r_alu = 3'b110;
      6'h24:        r_alu = 3'b000;
      6'h25:        r_alu = 3'b001;
      6'h2a:        r_alu = 3'b111;
      default:      r_alu = 3'bxxx;
    endcase
  endfunction

  // A cycle where only the state is known; every other control is 0 and memready is arbitrary.
  function automatic cyc_t blank(input logic [3:0] st);
    cyc_t c;
    c.st = st; c.pcen = 0; c.iord = 0; c.irw = 0; c.memw = 0; c.m2r = 0; c.rdst = 0;
    c.regw = 0; c.asrca = 0; c.asrcb = 0; c.pcsrc = 0; c.alu = 0; c.sext = 0; c.sh16 = 0;
    c.ill = 0; c.rdy = 1'($urandom_range(0, 1));
    return c;
  endfunction

  // Expands one instruction into its expected per-cycle control trace.
  // fst/mst: memready-low cycles in FETCH / in the memory access (-1 = random 0..2).
  task automatic build(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                       input int fst, input int mst);
    cyc_t c;
    int n, m;
    n = (fst < 0) ? $urandom_range(0, 2) : fst;
    m = (mst < 0) ? $urandom_range(0, 2) : mst;
    for (int i = 0; i < n; i++) begin
      c = blank(0); c.asrcb = 2'b01; c.alu = 3'b010; c.rdy = 0; q.push_back(c);
    end
    c = blank(0); c.asrcb = 2'b01; c.alu = 3'b010; c.rdy = 1; c.irw = 1; c.pcen = 1; q.push_back(c);
    c = blank(1); c.asrcb = 2'b11; c.alu = 3'b010; c.sext = 1; q.push_back(c);
    if (op == LW || op == SW) begin
      c = blank(2); c.asrca = 1; c.asrcb = 2'b10; c.alu = 3'b010; c.sext = 1; q.push_back(c);
      if (op == LW) begin
        for (int i = 0; i < m; i++) begin
          c = blank(3); c.iord = 1; c.rdy = 0; q.push_back(c);
        end
        c = blank(3); c.iord = 1; c.rdy = 1; q.push_back(c);
        c = blank(4); c.m2r = 1; c.regw = 1; q.push_back(c);
      end else begin
        for (int i = 0; i < m; i++) begin
          c = blank(5); c.iord = 1; c.memw = 1; c.rdy = 0; q.push_back(c);
        end
        c = blank(5); c.iord = 1; c.memw = 1; c.rdy = 1; q.push_back(c);
      end
    end else if (op == RT) begin
      c = blank(6); c.asrca = 1; c.alu = r_alu(funct); q.push_back(c);
      c = blank(7); c.rdst = 1; c.regw = 1; q.push_back(c);
    end else if (op == BEQ) begin
      c = blank(8); c.asrca = 1; c.alu = 3'b110; c.pcsrc = 2'b01; c.pcen = zero; q.push_back(c);
    end else if (op == J) begin
      c = blank(11); c.pcsrc = 2'b10; c.pcen = 1; q.push_back(c);
    end else begin
      c = blank(9); c.asrca = 1; c.asrcb = 2'b10;
      c.alu = (op == ORI) ? 3'b001 : 3'b010;
      c.sext = (op == ADDI || op == ADDIU);
      c.sh16 = (op == LUI);
      q.push_back(c);
      c = blank(10); c.regw = 1; q.push_back(c);
    end
  endtask

  task automatic compare(input cyc_t c);
    chk("state", 8'(ifh.state), 8'(c.st));
    chk("pcen", 8'(ifh.pcen), 8'(c.pcen));
    chk("iord", 8'(ifh.iord), 8'(c.iord));
    chk("irwrite", 8'(ifh.irwrite), 8'(c.irw));
    chk("memwrite", 8'(ifh.memwrite), 8'(c.memw));
    chk("memtoreg", 8'(ifh.memtoreg), 8'(c.m2r));
    chk("regdst", 8'(ifh.regdst), 8'(c.rdst));
    chk("regwrite", 8'(ifh.regwrite), 8'(c.regw));
    chk("alusrca", 8'(ifh.alusrca), 8'(c.asrca));
    chk("alusrcb", 8'(ifh.alusrcb), 8'(c.asrcb));
    chk("pcsrc", 8'(ifh.pcsrc), 8'(c.pcsrc));
    chk("alucontrol", 8'(ifh.alucontrol), 8'(c.alu));
    chk("signext", 8'(ifh.signext), 8'(c.sext));
    chk("shiftl16", 8'(ifh.shiftl16), 8'(c.sh16));
    chk("illegal", 8'(ifh.illegal), 8'(c.ill));
  endtask

  // Plays up to n expected cycles; entered and left at posedge+1.
  task automatic run(input int n);
    cyc_t c;
    int k;
    k = 0;
    while (q.size() > 0 && k < n) begin
      c = q.pop_front();
      k++;
      ifh.memready = c.rdy;
      @(negedge clk);
      compare(c);
      @(posedge clk); #1;
    end
    q.delete();
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                       input int fst, input int mst);
    ifh.op = op; ifh.funct = funct; ifh.zero = zero;
    build(op, funct, zero, fst, mst);
    run(1000);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic illegal_case(input logic [5:0] op, input logic [5:0] funct, input int hold);
    ifh.op = op; ifh.funct = funct; ifh.memready = 1'b1;
    @(negedge clk); chk("ill_fetch", 8'(ifh.state), 8'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("ill_decode", 8'(ifh.state), 8'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("nop_state", 8'(ifn.state), 8'd0);
    chk("nop_illegal", 8'(ifn.illegal), 8'd0);
    chk("nop_regwrite", 8'(ifn.regwrite), 8'd0);
    for (int i = 0; i < hold; i++) begin
      ifh.memready = 1'($urandom_range(0, 1));
      chk("halt_state", 8'(ifh.state), 8'd15);
      chk("halt_illegal", 8'(ifh.illegal), 8'd1);
      chk("halt_enables", {4'd0, ifh.pcen, ifh.irwrite, ifh.memwrite, ifh.regwrite}, 8'd0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    pulse_reset();
    ifh.memready = 1'b0;
    @(negedge clk); chk("halt_reset_state", 8'(ifh.state), 8'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [9];
    logic [5:0] fns [7];
    logic [5:0] rop, rfn;
    ops = '{LW, SW, RT, BEQ, ADDI, ADDIU, ORI, LUI, J};
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2a};

    // Reset: enables blocked even though FETCH with memready=1 would assert them.
    reset = 1'b1; ifh.op = LW; ifh.funct = 6'h20; ifh.zero = 1'b0; ifh.memready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_enables", {4'd0, ifh.pcen, ifh.irwrite, ifh.memwrite, ifh.regwrite}, 8'd0);
      chk("rst_state", 8'(ifh.state), 8'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    instr(LW, 6'h20, 1'b0, 0, 0);
    ifh.memready = 1'b0;
    @(negedge clk); chk("lw_back_to_fetch", 8'(ifh.state), 8'd0);
    @(posedge clk); #1;

    instr(SW, 6'h20, 1'b0, 0, 2);
    instr(BEQ, 6'h20, 1'b1, 0, 0);
    instr(BEQ, 6'h20, 1'b0, 0, 0);
    instr(RT, 6'h2a, 1'b0, 0, 0);
    instr(LUI, 6'h00, 1'b0, 0, 0);
    instr(ORI, 6'h00, 1'b0, 1, 0);
    instr(J, 6'h00, 1'b0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      rop = ops[$urandom_range(0, 8)];
      rfn = fns[$urandom_range(0, 6)];
      instr(rop, rfn, 1'($urandom_range(0, 1)), -1, -1);
    end

    // Reset arriving mid-store while memory is still busy.
    ifh.op = SW; ifh.funct = 6'h00; ifh.zero = 1'b0;
    build(SW, 6'h00, 1'b0, 0, 0);
    run(3);
    ifh.memready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rstmw_state", 8'(ifh.state), 8'd5);
    chk("rstmw_memwrite", 8'(ifh.memwrite), 8'd0);
    chk("rstmw_enables", {4'd0, ifh.pcen, ifh.irwrite, ifh.memwrite, ifh.regwrite}, 8'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); chk("rstmw_after", 8'(ifh.state), 8'd0);
    @(posedge clk); #1;

    illegal_case(RT, 6'b000111, 10);
    illegal_case(6'b111111, 6'h20, 3);

    instr(ADDI, 6'h00, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
